// File: rtl/pattern_pkg.sv
// Shared constants and types for the pattern detector and its event logger.
package pattern_pkg;

    // Default event FIFO depth, timestamp width and match counter width
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TS_W  = 16;
    localparam int DEF_CNT_W = 8;

    // Pattern detector state encoding
    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_S1   = 2'd1,
        DET_S2   = 2'd2,
        DET_HIT  = 2'd3
    } det_state_t;

    // Occupancy counter width: must be able to represent DEPTH itself
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO. Occupancy is tracked explicitly and is the
// only source of full/empty, so the pointers can simply wrap modulo DEPTH.
module event_fifo
    import pattern_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_TS_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [level_w(DEPTH)-1:0]  level,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // A pop on an empty FIFO is ignored; a push while full is only taken
    // when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage carries no reset: contents are meaningless while level is 0
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign valid = !empty;
    assign level = level_q;

endmodule

// File: rtl/match_event_logger.sv
// Timestamps each sampled match into an event FIFO, counts all matches with
// saturation and flags (sticky) any event dropped because the FIFO was full.
module match_event_logger
    import pattern_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       match_in,
    input  logic                       ev_ready,
    input  logic                       ov_clr,
    output logic                       ev_valid,
    output logic [TS_W-1:0]            ev_ts,
    output logic [level_w(DEPTH)-1:0]  ev_level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           match_cnt
);

    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ov_q;
    logic             full;
    logic             pop_fire;
    logic             drop;

    assign pop_fire = ev_valid && ev_ready;
    // Room is made on the same edge if the head is leaving
    assign drop     = match_in && full && !pop_fire;

    // Free-running timestamp; the pre-edge value stamps the event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ts_q <= '0;
        else
            ts_q <= ts_q + TS_W'(1);
    end

    // Saturating count of every sampled match, dropped or not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (match_in && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    // Sticky overflow; a drop on the clearing edge keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ov_q <= 1'b0;
        else if (drop)
            ov_q <= 1'b1;
        else if (ov_clr)
            ov_q <= 1'b0;
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (match_in),
        .pop     (ev_ready),
        .wdata   (ts_q),
        .rdata   (ev_ts),
        .valid   (ev_valid),
        .level   (ev_level),
        .full    (full)
    );

    assign overflow  = ov_q;
    assign match_cnt = cnt_q;

endmodule
